// File: rtl/rv32i_alu_pkg.sv
// Shared constants for the RV32I ALU: datapath widths, opcode encodings and a bit-reverse helper.
package rv32i_alu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned SEL_W   = 4;

    // {funct3, bit30}; sel[0] is 0 wherever it is a don't-care
    localparam logic [SEL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [SEL_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [SEL_W-1:0] ALU_SLL  = 4'b0010;
    localparam logic [SEL_W-1:0] ALU_SLT  = 4'b0100;
    localparam logic [SEL_W-1:0] ALU_SLTU = 4'b0110;
    localparam logic [SEL_W-1:0] ALU_XOR  = 4'b1000;
    localparam logic [SEL_W-1:0] ALU_SRL  = 4'b1010;
    localparam logic [SEL_W-1:0] ALU_SRA  = 4'b1011;
    localparam logic [SEL_W-1:0] ALU_OR   = 4'b1100;
    localparam logic [SEL_W-1:0] ALU_AND  = 4'b1110;

    function automatic logic [XLEN-1:0] bitrev(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rv32i_alu_shifter.sv
// Five-stage logarithmic barrel shifter; left shifts reuse the right-shift network via bit reversal.
module rv32i_alu_shifter
    import rv32i_alu_pkg::*;
(
    input  logic [XLEN-1:0]    a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               direction,
    input  logic               arith,
    output logic [XLEN-1:0]    y_c
);

    logic              fill;
    logic [XLEN-1:0]   st [0:SHAMT_W];

    // sign fill only for arithmetic right shifts
    assign fill  = direction & arith & a[XLEN-1];
    assign st[0] = direction ? a : bitrev(a);

    for (genvar i = 0; i < int'(SHAMT_W); i++) begin : g_stage
        localparam int unsigned SH = 1 << i;
        assign st[i+1] = shamt[i] ? {{SH{fill}}, st[i][XLEN-1:SH]} : st[i];
    end

    assign y_c = direction ? st[SHAMT_W] : bitrev(st[SHAMT_W]);

endmodule

// File: rtl/rv32i_alu.sv
// Registered RV32I integer ALU: result and zero flag captured one clock after the operands.
module rv32i_alu
    import rv32i_alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [SEL_W-1:0] sel,
    output logic [XLEN-1:0]  Y,
    output logic             z
);

    logic [2:0]      f3;
    logic            sub;
    logic            sh_right;
    logic            sh_arith;
    logic [XLEN:0]   sum;
    logic            carry;
    logic            ovf;
    logic            lt_s;
    logic            lt_u;
    logic [XLEN-1:0] sh_y;
    logic [XLEN-1:0] result;

    assign f3 = sel[3:1];

    // sel[0] is consulted only for ADD/SUB and SRL/SRA so X there cannot leak elsewhere
    assign sub      = (f3 == ALU_ADD[3:1]) ? sel[0] : 1'b1;
    assign sh_right = (f3 != ALU_SLL[3:1]);
    assign sh_arith = (f3 == ALU_SRL[3:1]) ? sel[0] : 1'b0;

    // shared adder: a + ~b + 1 for SUB and for the compares
    assign sum   = {1'b0, a} + {1'b0, b ^ {XLEN{sub}}} + (XLEN+1)'(sub);
    assign carry = sum[XLEN];
    assign ovf   = (a[XLEN-1] ^ b[XLEN-1]) & (sum[XLEN-1] ^ a[XLEN-1]);
    assign lt_s  = sum[XLEN-1] ^ ovf;
    assign lt_u  = ~carry;

    rv32i_alu_shifter u_shifter (
        .a         (a),
        .shamt     (b[SHAMT_W-1:0]),
        .direction (sh_right),
        .arith     (sh_arith),
        .y_c       (sh_y)
    );

    always_comb begin
        result = '0;
        case (f3)
            ALU_ADD[3:1]:  result = sum[XLEN-1:0];
            ALU_SLL[3:1]:  result = sh_y;
            ALU_SLT[3:1]:  result = XLEN'(lt_s);
            ALU_SLTU[3:1]: result = XLEN'(lt_u);
            ALU_XOR[3:1]:  result = a ^ b;
            ALU_SRL[3:1]:  result = sh_y;
            ALU_OR[3:1]:   result = a | b;
            ALU_AND[3:1]:  result = a & b;
            default:       result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Y <= '0;
            z <= 1'b1;
        end else begin
            Y <= result;
            z <= (result == '0);
        end
    end

endmodule

// File: tb/tb_rv32i_alu.sv
// Directed self-checking bench for rv32i_alu with hand-computed expected results.
module tb_rv32i_alu;
    import rv32i_alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [31:0] Y;
    logic        z;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    rv32i_alu dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .sel (sel),
        .Y   (Y),
        .z   (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] ey, input logic ez);
        n_cmp++;
        assert (Y === ey) else begin
            n_err++;
            $error("FAIL %s: Y=%h expected %h", tag, Y, ey);
        end
        n_cmp++;
        assert (z === ez) else begin
            n_err++;
            $error("FAIL %s.z: z=%b expected %b", tag, z, ez);
        end
    endtask

    // drive one operation, capture on the next edge, check just after it
    task automatic step(input string tag, input logic r, input logic [3:0] s,
                        input logic [31:0] ai, input logic [31:0] bi,
                        input logic [31:0] ey, input logic ez);
        @(negedge clk);
        rst = r;
        sel = s;
        a   = ai;
        b   = bi;
        @(posedge clk);
        #1;
        check(tag, ey, ez);
    endtask

    initial begin
        logic [3:0] s;
        rst = 1'b1;
        a   = 32'd1;
        b   = 32'd5;
        sel = ALU_ADD;
        repeat (3) @(posedge clk);
        #1;
        check("reset", 32'h0, 1'b1);

        step("rel_add",   1'b0, ALU_ADD,  32'd1, 32'd5, 32'd6, 1'b0);
        step("sub_neg",   1'b0, ALU_SUB,  32'd1, 32'd5, 32'hFFFF_FFFC, 1'b0);
        step("sub_zero",  1'b0, ALU_SUB,  32'd5, 32'd5, 32'h0, 1'b1);
        step("add_wrap",  1'b0, ALU_ADD,  32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1);

        step("sll",       1'b0, ALU_SLL,  32'd1, 32'd5, 32'h20, 1'b0);
        step("sll_s1",    1'b0, 4'b0011,  32'd1, 32'd5, 32'h20, 1'b0);
        step("srl",       1'b0, ALU_SRL,  32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
        step("sra",       1'b0, ALU_SRA,  32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
        step("sll_hi",    1'b0, ALU_SLL,  32'd1, 32'h25, 32'h20, 1'b0);
        step("srl_hi",    1'b0, ALU_SRL,  32'h8000_0000, 32'h25, 32'h0400_0000, 1'b0);
        step("sra_hi",    1'b0, ALU_SRA,  32'h8000_0000, 32'h25, 32'hFC00_0000, 1'b0);
        step("sra_0",     1'b0, ALU_SRA,  32'h8000_0001, 32'd0, 32'h8000_0001, 1'b0);
        step("sra_31",    1'b0, ALU_SRA,  32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0);
        step("srl_31",    1'b0, ALU_SRL,  32'h8000_0000, 32'd31, 32'h1, 1'b0);
        step("sll_31",    1'b0, ALU_SLL,  32'd1, 32'd31, 32'h8000_0000, 1'b0);

        step("slt",       1'b0, ALU_SLT,  32'd1, 32'd5, 32'd1, 1'b0);
        step("sltu",      1'b0, ALU_SLTU, 32'd1, 32'd5, 32'd1, 1'b0);
        step("slt_min",   1'b0, ALU_SLT,  32'h8000_0000, 32'd0, 32'd1, 1'b0);
        step("sltu_min",  1'b0, ALU_SLTU, 32'h8000_0000, 32'd0, 32'd0, 1'b1);
        step("slt_gt",    1'b0, ALU_SLT,  32'd5, 32'd1, 32'd0, 1'b1);
        step("slt_m1",    1'b0, ALU_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        step("sltu_m1",   1'b0, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        step("slt_ovf",   1'b0, ALU_SLT,  32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b1);
        step("sltu_ovf",  1'b0, ALU_SLTU, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1, 1'b0);
        step("slt_s1",    1'b0, 4'b0101,  32'h8000_0000, 32'd0, 32'd1, 1'b0);

        step("xor",       1'b0, ALU_XOR,  32'd1, 32'd5, 32'd4, 1'b0);
        step("or",        1'b0, ALU_OR,   32'd1, 32'd5, 32'd5, 1'b0);
        step("and",       1'b0, ALU_AND,  32'd1, 32'd5, 32'd1, 1'b0);
        step("xor_s1",    1'b0, 4'b1001,  32'd1, 32'd5, 32'd4, 1'b0);
        step("or_s1",     1'b0, 4'b1101,  32'd1, 32'd5, 32'd5, 1'b0);
        step("and_s1",    1'b0, 4'b1111,  32'd1, 32'd5, 32'd1, 1'b0);
        s = ALU_XOR; s[0] = 1'bx;
        step("xor_sx",    1'b0, s,        32'd1, 32'd5, 32'd4, 1'b0);
        s = ALU_OR;  s[0] = 1'bx;
        step("or_sx",     1'b0, s,        32'd1, 32'd5, 32'd5, 1'b0);
        s = ALU_AND; s[0] = 1'bx;
        step("and_sx",    1'b0, s,        32'd1, 32'd5, 32'd1, 1'b0);
        s = ALU_SLTU; s[0] = 1'bx;
        step("sltu_sx",   1'b0, s,        32'd1, 32'd5, 32'd1, 1'b0);

        // back-to-back across all codes, a new op every cycle
        step("b2b_add",   1'b0, ALU_ADD,  32'hF0F0_000F, 32'd4, 32'hF0F0_0013, 1'b0);
        step("b2b_sub",   1'b0, ALU_SUB,  32'hF0F0_000F, 32'd4, 32'hF0F0_000B, 1'b0);
        step("b2b_sll",   1'b0, ALU_SLL,  32'hF0F0_000F, 32'd4, 32'h0F00_00F0, 1'b0);
        step("b2b_slt",   1'b0, ALU_SLT,  32'hF0F0_000F, 32'd4, 32'd1, 1'b0);
        step("b2b_sltu",  1'b0, ALU_SLTU, 32'hF0F0_000F, 32'd4, 32'd0, 1'b1);
        step("b2b_xor",   1'b0, ALU_XOR,  32'hF0F0_000F, 32'd4, 32'hF0F0_000B, 1'b0);
        step("b2b_srl",   1'b0, ALU_SRL,  32'hF0F0_000F, 32'd4, 32'h0F0F_0000, 1'b0);
        step("b2b_sra",   1'b0, ALU_SRA,  32'hF0F0_000F, 32'd4, 32'hFF0F_0000, 1'b0);
        step("b2b_or",    1'b0, ALU_OR,   32'hF0F0_000F, 32'd4, 32'hF0F0_000F, 1'b0);
        step("b2b_and",   1'b0, ALU_AND,  32'hF0F0_000F, 32'd4, 32'd4, 1'b0);

        step("mid_rst",   1'b1, ALU_ADD,  32'd1, 32'd5, 32'h0, 1'b1);
        step("post_rst",  1'b0, ALU_ADD,  32'd2, 32'd3, 32'd5, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
